// File: rtl/mmio_data_decoder.sv
// mmio_data_decoder
//   Data-side address decoder for the multicycle MIPS core. It splits CPU data
//   accesses between a word RAM (addr[IO_SEL_BIT]=0) and a register-mapped IO
//   window (addr[IO_SEL_BIT]=1). The IO window holds STATUS (W1C button
//   pending flags), IRQ_EN, SWITCH (synchronised switches) and NUM_OUT
//   writable 32-bit output registers.
//
//   Optional feature macro: MMIO_DEC_ADDR_ERR_EN
//     When defined, STATUS[31] is a sticky address-error flag. It sets on any
//     misaligned, unmapped-IO or out-of-range RAM address. Writing STATUS with
//     wd[31]=1 clears it. The flag also drives irq without a mask.
//
// Ports
//   clk       system clock; all state updates on the rising edge
//   reset     asynchronous, active-low reset
//   we        write enable for the current access
//   addr      byte address
//   wd        write data
//   rd        read data (combinational)
//   btn       raw asynchronous buttons
//   sw        raw asynchronous switches
//   out_regs  output register i at [32*i+31:32*i]
//   irq       registered interrupt request
module mmio_data_decoder #(
  parameter int unsigned RAM_DEPTH  = 64,
  parameter int unsigned IO_SEL_BIT = 7,
  parameter int unsigned NUM_BTN    = 2,
  parameter int unsigned SW_W       = 16,
  parameter int unsigned NUM_OUT    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [31:0]            addr,
  input  logic [31:0]            wd,
  output logic [31:0]            rd,
  input  logic [NUM_BTN-1:0]     btn,
  input  logic [SW_W-1:0]        sw,
  output logic [NUM_OUT*32-1:0]  out_regs,
  output logic                   irq
);

  localparam int unsigned AW       = $clog2(RAM_DEPTH);
  localparam int unsigned OUT_BASE = 3;
  localparam logic [3:0]  OUT_END  = 4'(OUT_BASE + NUM_OUT);

  logic              io_sel;
  logic [3:0]        io_idx;
  logic [AW-1:0]     ram_idx;
  logic              ram_we;
  logic              io_we;
  logic              status_wr;
  logic              irq_en_wr;

  logic [31:0]       mem [RAM_DEPTH];

  logic [NUM_BTN-1:0] btn_s1, btn_s2, btn_prev;
  logic [SW_W-1:0]    sw_s1, sw_s2;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] irq_en;
  logic [31:0]        out_q [NUM_OUT];
  logic               err;

  assign io_sel    = addr[IO_SEL_BIT];
  assign io_idx    = addr[5:2];
  assign ram_idx   = addr[AW+1:2];
  assign ram_we    = we & ~io_sel;
  assign io_we     = we & io_sel;
  assign status_wr = io_we && (io_idx == 4'd0);
  assign irq_en_wr = io_we && (io_idx == 4'd1);

  // Only part of the address and data buses is decoded.
  logic unused_bits;
  assign unused_bits = ^{addr, wd};

  // Word RAM: synchronous write, asynchronous read, no reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= wd;
  end

  // Input synchronisers; btn_prev is the extra stage for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
    end else begin
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
    end
  end

  assign rise = btn_s2 & ~btn_prev;

  // Clear is applied before the new rise is ORed in, so a set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      irq_en  <= '0;
      for (int unsigned i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
    end else begin
      pending <= (pending & ~(status_wr ? wd[NUM_BTN-1:0] : '0)) | rise;
      if (irq_en_wr) irq_en <= wd[NUM_BTN-1:0];
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        if (io_we && (io_idx == 4'(OUT_BASE + i))) out_q[i] <= wd;
      end
    end
  end

`ifdef MMIO_DEC_ADDR_ERR_EN
  logic [31:0] ram_word;
  logic        addr_bad;
  logic        err_clr;
  logic        err_q;

  // RAM word index over every bit below the IO select, not just the decoded ones.
  assign ram_word = 32'(addr[31:2]) & ((32'd1 << (IO_SEL_BIT - 2)) - 32'd1);
  assign addr_bad = (addr[1:0] != 2'b00) |
                    (io_sel ? (io_idx >= OUT_END) : (ram_word >= 32'(RAM_DEPTH)));
  assign err_clr  = status_wr & wd[31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= addr_bad | (err_q & ~err_clr);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (|(pending & irq_en)) | err;
  end

  always_comb begin
    rd = '0;
    if (!io_sel) begin
      rd = mem[ram_idx];
    end else begin
      case (io_idx)
        4'd0: begin
          rd[NUM_BTN-1:0] = pending;
          rd[31]          = err;
        end
        4'd1: rd[NUM_BTN-1:0] = irq_en;
        4'd2: rd[SW_W-1:0]    = sw_s2;
        default: begin
          for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (io_idx == 4'(OUT_BASE + i)) rd = out_q[i];
          end
        end
      endcase
    end
  end

  always_comb begin
    out_regs = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) out_regs[32*i +: 32] = out_q[i];
  end

endmodule
